// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: controller states, iteration
// count and the ALU flag bundle.
package div_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } div_state_e;

    localparam int DIV_ITERS = 32;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } div_flags_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the dividend MSB into the partial
// remainder and subtract the divisor if it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             msb_i,
    input  logic [WIDTH-1:0] dvsr_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             qbit_o
);

    logic [WIDTH:0] shifted_s;

    // Compare at WIDTH+1 bits; the subtraction result fits in WIDTH bits
    // because the incoming remainder is always below the divisor.
    always_comb begin
        shifted_s = {rem_i, msb_i};
        qbit_o    = (shifted_s >= {1'b0, dvsr_i});
        if (qbit_o) begin
            rem_o = shifted_s[WIDTH-1:0] - dvsr_i;
        end else begin
            rem_o = shifted_s[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle restoring divider sequencer: start/ready handshake, signed
// pre/post-processing, registered quotient/residue/flags and a done pulse.
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_ITERS,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sign,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] residue,
    output logic             Z,
    output logic             N,
    output logic             C,
    output logic             V
);

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             sign_q, sign_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d, dvnd_q, dvnd_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d;
    logic             dbz_q, dbz_d, ovf_q, ovf_d;
    logic [WIDTH-1:0] quotient_q, quotient_d, residue_q, residue_d;
    div_flags_t       flags_q, flags_d;
    logic             ready_q, ready_d, done_q, done_d;

    logic [WIDTH-1:0] step_rem_s, q_fix_s, r_fix_s;
    logic             step_qbit_s;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i  (rem_q),
        .msb_i  (dvnd_q[WIDTH-1]),
        .dvsr_i (dvsr_q),
        .rem_o  (step_rem_s),
        .qbit_o (step_qbit_s)
    );

    // Sign correction of the unsigned datapath result.
    always_comb begin
        if (q_neg_q) begin
            q_fix_s = -quo_q;
        end else begin
            q_fix_s = quo_q;
        end
        if (r_neg_q) begin
            r_fix_s = -rem_q;
        end else begin
            r_fix_s = rem_q;
        end
    end

    // Next-state and datapath-register update logic.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        sign_d     = sign_q;
        dvsr_d     = dvsr_q;
        dvnd_d     = dvnd_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        dbz_d      = dbz_q;
        ovf_d      = ovf_q;
        quotient_d = quotient_q;
        residue_d  = residue_q;
        flags_d    = flags_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    sign_d  = sign;
                    state_d = S_PREP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PREP: begin
                if (sign_q && a_q[WIDTH-1]) begin
                    dvsr_d = -a_q;
                end else begin
                    dvsr_d = a_q;
                end
                if (sign_q && b_q[WIDTH-1]) begin
                    dvnd_d = -b_q;
                end else begin
                    dvnd_d = b_q;
                end
                q_neg_d = sign_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                r_neg_d = sign_q & b_q[WIDTH-1];
                rem_d   = '0;
                quo_d   = '0;
                cnt_d   = '0;
                ovf_d   = sign_q && (b_q == {1'b1, {(WIDTH-1){1'b0}}}) && (a_q == '1);
                dbz_d   = (a_q == '0);
                if (a_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                rem_d  = step_rem_s;
                quo_d  = {quo_q[WIDTH-2:0], step_qbit_s};
                dvnd_d = {dvnd_q[WIDTH-2:0], 1'b0};
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_ITER;
                end
            end
            S_FIX: begin
                if (dbz_q) begin
                    quotient_d = '1;
                    residue_d  = b_q;
                    flags_d    = '{z: 1'b0, n: 1'b0, c: 1'b1, v: 1'b0};
                end else begin
                    quotient_d = q_fix_s;
                    residue_d  = r_fix_s;
                    flags_d.z  = (q_fix_s == '0);
                    flags_d.n  = sign_q & q_fix_s[WIDTH-1];
                    flags_d.c  = 1'b0;
                    flags_d.v  = ovf_q;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        ready_d = (state_d == S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            sign_q     <= 1'b0;
            dvsr_q     <= '0;
            dvnd_q     <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            dbz_q      <= 1'b0;
            ovf_q      <= 1'b0;
            quotient_q <= '0;
            residue_q  <= '0;
            flags_q    <= '0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sign_q     <= sign_d;
            dvsr_q     <= dvsr_d;
            dvnd_q     <= dvnd_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            dbz_q      <= dbz_d;
            ovf_q      <= ovf_d;
            quotient_q <= quotient_d;
            residue_q  <= residue_d;
            flags_q    <= flags_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
        end
    end

    assign ready    = ready_q;
    assign done     = done_q;
    assign quotient = quotient_q;
    assign residue  = residue_q;
    assign Z        = flags_q.z;
    assign N        = flags_q.n;
    assign C        = flags_q.c;
    assign V        = flags_q.v;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: directed corner cases, handshake and
// reset scenarios, then random operands against an arithmetic reference model.
module tb_div_seq_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, start, sign;
    logic [W-1:0] A, B;
    logic         ready, done, Z, N, C, V;
    logic [W-1:0] quotient, residue;

    int n_assert = 0;
    int n_fail   = 0;

    div_seq_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .sign(sign),
        .ready(ready), .done(done), .quotient(quotient), .residue(residue),
        .Z(Z), .N(N), .C(C), .V(V)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic on 64-bit signed or 32-bit unsigned values.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic [3:0] f, output int lat);
        longint la, lb, q64, r64;
        if (a == 32'd0) begin
            q   = 32'hFFFF_FFFF;
            r   = b;
            f   = 4'b0010;
            lat = 2;
        end else if (s) begin
            la  = longint'($signed(a));
            lb  = longint'($signed(b));
            q64 = lb / la;
            r64 = lb % la;
            q   = q64[31:0];
            r   = r64[31:0];
            f   = {q == 32'd0, q[31], 1'b0, (b == 32'h8000_0000) && (a == 32'hFFFF_FFFF)};
            lat = 34;
        end else begin
            q   = b / a;
            r   = b % a;
            f   = {q == 32'd0, 1'b0, 1'b0, 1'b0};
            lat = 34;
        end
    endtask

    // Starts at a negedge with the DUT idle; returns at the negedge of the
    // idle cycle following done. poke_at >= 0 pulses a rogue start mid-run.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input string tag, input int poke_at);
        logic [W-1:0] eq, er;
        logic [3:0]   ef;
        int           lat, j;
        bit           seen;
        model(a, b, s, eq, er, ef, lat);
        check({tag, ".ready_before"}, W'(ready), 32'd1);
        A = a; B = b; sign = s; start = 1'b1;
        @(posedge clk);
        j = 0;
        seen = 1'b0;
        while (!seen && j < 100) begin
            @(negedge clk);
            start = 1'b0;
            if (j == poke_at) begin
                A = ~a; B = b + 32'd1; sign = ~s; start = 1'b1;
                check({tag, ".ready_busy"}, W'(ready), 32'd0);
            end
            if (done) seen = 1'b1;
            else j++;
        end
        check({tag, ".latency"}, W'(j), W'(lat));
        check({tag, ".quotient"}, quotient, eq);
        check({tag, ".residue"}, residue, er);
        check({tag, ".flags_ZNCV"}, W'({Z, N, C, V}), W'(ef));
        @(negedge clk);
        check({tag, ".done_single"}, W'(done), 32'd0);
        check({tag, ".ready_after"}, W'(ready), 32'd1);
    endtask

    initial begin
        int  dsel;
        bit  seen;
        logic [W-1:0] ra, rb;
        rst = 1'b1; start = 1'b0; sign = 1'b0; A = '0; B = '0;
        repeat (3) @(negedge clk);
        check("reset.ready", W'(ready), 32'd1);
        check("reset.done", W'(done), 32'd0);
        check("reset.quotient", quotient, 32'd0);
        check("reset.residue", residue, 32'd0);
        check("reset.flags", W'({Z, N, C, V}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(32'd7, 32'd100, 1'b0, "unsigned", -1);
        run_op(32'd7, 32'hFFFF_FF9C, 1'b1, "signed_negB", -1);
        run_op(32'hFFFF_FFF9, 32'd100, 1'b1, "signed_negA", -1);
        run_op(32'd0, 32'd55, 1'b0, "dbz", -1);
        run_op(32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "ovf_signed", -1);
        run_op(32'hFFFF_FFFF, 32'h8000_0000, 1'b0, "ovf_unsigned", -1);
        run_op(32'd3, 32'd1000, 1'b0, "poke_mid_iter", 10);
        run_op(32'd13, 32'd200, 1'b0, "back_to_back", -1);

        // Reset during ITER cycle 10, then make sure no done pulse escapes.
        A = 32'd17; B = 32'd12345; sign = 1'b0; start = 1'b1;
        @(posedge clk);
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            start = 1'b0;
            if (j == 11) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        check("midrst.ready", W'(ready), 32'd1);
        check("midrst.done", W'(done), 32'd0);
        check("midrst.quotient", quotient, 32'd0);
        check("midrst.residue", residue, 32'd0);
        check("midrst.flags", W'({Z, N, C, V}), 32'd0);
        seen = 1'b0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("midrst.no_done", W'(seen), 32'd0);
        run_op(32'd3, 32'd9, 1'b0, "after_rst", -1);

        for (int i = 0; i < 24; i++) begin
            dsel = $urandom_range(0, 4);
            rb = $urandom;
            case (dsel)
                0: ra = 32'd0;
                1: ra = 32'($urandom_range(1, 20));
                2: ra = -32'($urandom_range(1, 20));
                3: begin ra = 32'hFFFF_FFFF; rb = 32'h8000_0000; end
                default: ra = $urandom;
            endcase
            run_op(ra, rb, 1'($urandom_range(0, 1)), $sformatf("rand%0d", i), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
